// File: rtl/ppu_bg_row_fetch.sv
// Background-layer row fetcher: walks the scrolled tile map, fetches 4bpp pattern rows, writes one row buffer line.
// Optional PPU_BG_TRANSPARENT_SKIP_EN suppresses writes of color-0 pixels.
module ppu_bg_row_fetch #(
  parameter int unsigned ROW_PIXELS  = 320,
  parameter int unsigned VRAM_AW     = 16,
  parameter int unsigned VRAM_RD_LAT = 1,
  parameter logic [VRAM_AW-1:0] TMAP_BASE = 16'h0000,
  parameter logic [VRAM_AW-1:0] PAT_BASE  = 16'h2000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               row_start,
  input  logic [7:0]         next_row,
  input  logic [31:0]        bgscroll,
  output logic               busy,
  output logic               done,
  output logic               overrun,
  output logic               vram_rden,
  output logic [VRAM_AW-1:0] vram_rdaddr,
  input  logic [31:0]        vram_rddata,
  output logic               row_wren,
  output logic [8:0]         row_wraddr,
  output logic [7:0]         row_wrdata
);
  localparam int unsigned N_TILES = ROW_PIXELS / 8 + 1;

  typedef enum logic [2:0] {IDLE, MAP_REQ, MAP_WAIT, PAT_REQ, PAT_WAIT, EMIT} state_t;

  state_t       state_q, state_d;
  logic [5:0]   k_q, k_d;
  logic [2:0]   p_q, p_d;
  logic [8:0]   y_q, y_d;
  logic [8:0]   sx_q, sx_d;
  logic [15:0]  ent_q, ent_d;
  logic [31:0]  pat_q, pat_d;
  logic         done_q, done_d;
  logic         ovr_q, ovr_d;
  logic [VRAM_RD_LAT-1:0] vld_pipe_q, vld_pipe_d, vld_shift;

  logic [5:0]   col;
  logic [2:0]   fine_y;
  logic [VRAM_AW-1:0] map_addr, pat_addr;
  logic signed [9:0] x;
  logic [2:0]   pix;
  logic [3:0]   color;
  logic         in_range;

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign overrun   = ovr_q;
  assign vram_rden = (state_q == MAP_REQ) || (state_q == PAT_REQ);

  // Read-valid shift register; one request in flight at a time, so the top bit marks the returning word.
  generate
    if (VRAM_RD_LAT == 1) begin : g_lat1
      assign vld_shift = vram_rden;
    end else begin : g_latn
      assign vld_shift = {vld_pipe_q[VRAM_RD_LAT-2:0], vram_rden};
    end
  endgenerate

  assign col      = sx_q[8:3] + k_q;
  assign fine_y   = ent_q[15] ? ~y_q[2:0] : y_q[2:0];
  assign map_addr = TMAP_BASE + VRAM_AW'({y_q[8:3], col[5:1]});
  assign pat_addr = PAT_BASE + VRAM_AW'({ent_q[9:0], fine_y});

  assign x        = $signed({1'b0, k_q, p_q}) - $signed({7'b0, sx_q[2:0]});
  assign in_range = !x[9] && (x < $signed(10'(ROW_PIXELS)));
  assign pix      = p_q ^ {3{ent_q[14]}};
  assign color    = pat_q[{pix, 2'b00} +: 4];

  always_comb begin
    vram_rdaddr = '0;
    row_wren    = 1'b0;
    row_wraddr  = '0;
    row_wrdata  = '0;
    if (state_q == MAP_REQ) vram_rdaddr = map_addr;
    if (state_q == PAT_REQ) vram_rdaddr = pat_addr;
    if (state_q == EMIT) begin
      row_wraddr = x[8:0];
      row_wrdata = {ent_q[13:10], color};
`ifdef PPU_BG_TRANSPARENT_SKIP_EN
      row_wren   = in_range && (color != 4'h0);
`else
      row_wren   = in_range;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    p_d        = p_q;
    y_d        = y_q;
    sx_d       = sx_q;
    ent_d      = ent_q;
    pat_d      = pat_q;
    done_d     = 1'b0;
    ovr_d      = 1'b0;
    vld_pipe_d = vld_shift;
    if (row_start) begin
      // Restart drops anything still in flight for the aborted row.
      y_d        = 9'(next_row) + bgscroll[24:16];
      sx_d       = bgscroll[8:0];
      k_d        = '0;
      p_d        = '0;
      vld_pipe_d = '0;
      ovr_d      = busy;
      state_d    = MAP_REQ;
    end else begin
      case (state_q)
        MAP_REQ:  state_d = MAP_WAIT;
        MAP_WAIT: if (vld_pipe_q[VRAM_RD_LAT-1]) begin
          ent_d   = col[0] ? vram_rddata[31:16] : vram_rddata[15:0];
          state_d = PAT_REQ;
        end
        PAT_REQ:  state_d = PAT_WAIT;
        PAT_WAIT: if (vld_pipe_q[VRAM_RD_LAT-1]) begin
          pat_d   = vram_rddata;
          p_d     = '0;
          state_d = EMIT;
        end
        EMIT: begin
          p_d = p_q + 3'd1;
          if (p_q == 3'd7) begin
            if (k_q == 6'(N_TILES - 1)) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              k_d     = k_q + 6'd1;
              state_d = MAP_REQ;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      k_q        <= '0;
      p_q        <= '0;
      y_q        <= '0;
      sx_q       <= '0;
      ent_q      <= '0;
      pat_q      <= '0;
      done_q     <= 1'b0;
      ovr_q      <= 1'b0;
      vld_pipe_q <= '0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      p_q        <= p_d;
      y_q        <= y_d;
      sx_q       <= sx_d;
      ent_q      <= ent_d;
      pat_q      <= pat_d;
      done_q     <= done_d;
      ovr_q      <= ovr_d;
      vld_pipe_q <= vld_pipe_d;
    end
  end
endmodule

// File: tb/tb_ppu_bg_row_fetch.sv
// Directed bench for ppu_bg_row_fetch: VRAM model, row-buffer capture, immediate-assertion checks.
module tb_ppu_bg_row_fetch;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        row_start = 1'b0;
  logic [7:0]  next_row = '0;
  logic [31:0] bgscroll = '0;
  logic        busy, done, overrun, vram_rden, row_wren;
  logic [15:0] vram_rdaddr;
  logic [31:0] vram_rddata = '0;
  logic [8:0]  row_wraddr;
  logic [7:0]  row_wrdata;

  ppu_bg_row_fetch dut (
    .clk(clk), .rst_n(rst_n), .row_start(row_start), .next_row(next_row),
    .bgscroll(bgscroll), .busy(busy), .done(done), .overrun(overrun),
    .vram_rden(vram_rden), .vram_rdaddr(vram_rdaddr), .vram_rddata(vram_rddata),
    .row_wren(row_wren), .row_wraddr(row_wraddr), .row_wrdata(row_wrdata)
  );

  always #5 clk = ~clk;

  logic [31:0] vram [0:65535];
  always @(posedge clk) if (vram_rden) vram_rddata <= vram[vram_rdaddr];

  logic [7:0] rowbuf [0:511];
  int checks = 0, errors = 0;
  int tick_n, wr_cnt, bad_cnt, done_cnt, done_at, saved;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample the new cycle's outputs at the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    tick_n++;
    if (row_wren) begin
      rowbuf[row_wraddr] = row_wrdata;
      wr_cnt++;
      if (row_wraddr >= 9'd320) bad_cnt++;
    end
    if (done) begin
      done_cnt++;
      done_at = tick_n;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic start_row(input logic [7:0] r, input logic [31:0] s);
    next_row  = r;
    bgscroll  = s;
    row_start = 1'b1;
    tick_n = 0; wr_cnt = 0; bad_cnt = 0; done_cnt = 0; done_at = 0;
    tick();
    row_start = 1'b0;
    next_row  = 8'hAA;
    bgscroll  = 32'h01FF_01FF;
  endtask

  task automatic clear_buf();
    for (int i = 0; i < 512; i++) rowbuf[i] = 8'hFF;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) vram[i] = '0;
    for (int i = 0; i < 2048; i++) vram[i] = 32'h0801_0801;
    for (int i = 0; i < 8; i++) vram[16'h2008 + i] = 32'h7654_3210;
    clear_buf();

    #1;
    check("reset_outs", {28'd0, busy, done, overrun, vram_rden}, 32'h0);
    check("reset_wren", {31'd0, row_wren}, 32'h0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Row 0, no scroll, uniform tile1/pal2.
    start_row(8'd0, 32'h0);
    check("t1_busy", {31'd0, busy}, 32'h1);
    check("t1_rden", {31'd0, vram_rden}, 32'h1);
    check("t1_rdaddr", {16'd0, vram_rdaddr}, 32'h0);
    run(600);
    check("t1_done_at", done_at, 493);
    check("t1_done_cnt", done_cnt, 1);
    check("t1_wr_cnt", wr_cnt, 320);
    check("t1_bad_addr", bad_cnt, 0);
    check("t1_px0", {24'd0, rowbuf[0]}, 32'h20);
    check("t1_px13", {24'd0, rowbuf[13]}, 32'h25);
    check("t1_px319", {24'd0, rowbuf[319]}, 32'h27);
    check("t1_px320", {24'd0, rowbuf[320]}, 32'hFF);
    check("t1_idle", {31'd0, busy}, 32'h0);

    // scroll_x = 510: column 63 then wrap to column 0.
    vram[31] = 32'h0C02_0801;
    vram[0]  = 32'h0801_1003;
    for (int i = 0; i < 8; i++) begin
      vram[16'h2010 + i] = 32'h7654_3210;
      vram[16'h2018 + i] = 32'h7654_3210;
    end
    clear_buf();
    start_row(8'd0, 32'h0000_01FE);
    run(600);
    check("t2_x0", {24'd0, rowbuf[0]}, 32'h36);
    check("t2_x1", {24'd0, rowbuf[1]}, 32'h37);
    check("t2_x2", {24'd0, rowbuf[2]}, 32'h40);
    check("t2_x10", {24'd0, rowbuf[10]}, 32'h20);
    check("t2_wr_cnt", wr_cnt, 320);
    check("t2_done_at", done_at, 493);
    vram[31] = 32'h0801_0801;
    vram[0]  = 32'h0801_0801;

    // scroll_y = 5, row 3 -> map row 1, fine_y 0; vflip and hflip entries.
    vram[32] = 32'h5805_9404;
    vram[16'h2020] = 32'h1111_1111;
    vram[16'h2027] = 32'h7654_3210;
    vram[16'h2028] = 32'h7654_3210;
    vram[16'h202F] = 32'h1111_1111;
    clear_buf();
    start_row(8'd3, 32'h0005_0000);
    run(600);
    check("t3_vflip0", {24'd0, rowbuf[0]}, 32'h50);
    check("t3_vflip7", {24'd0, rowbuf[7]}, 32'h57);
    check("t3_hflip0", {24'd0, rowbuf[8]}, 32'h67);
    check("t3_hflip7", {24'd0, rowbuf[15]}, 32'h60);
    check("t3_px16", {24'd0, rowbuf[16]}, 32'h20);

    // Restart while busy.
    start_row(8'd0, 32'h0);
    run(99);
    next_row  = 8'd0;
    bgscroll  = 32'h0;
    row_start = 1'b1;
    saved = done_cnt;
    tick_n = 0; wr_cnt = 0; bad_cnt = 0; done_cnt = 0; done_at = 0;
    tick();
    row_start = 1'b0;
    check("t4_overrun", {31'd0, overrun}, 32'h1);
    check("t4_no_old_wr", {31'd0, row_wren}, 32'h0);
    check("t4_early_done", saved, 0);
    tick();
    check("t4_ovr_pulse", {31'd0, overrun}, 32'h0);
    run(600);
    check("t4_done_cnt", done_cnt, 1);
    check("t4_done_at", done_at, 493);
    check("t4_wr_cnt", wr_cnt, 320);

    // Async reset in the middle of EMIT.
    start_row(8'd0, 32'h0);
    run(54);
    check("t5_in_emit", {31'd0, row_wren}, 32'h1);
    #1 rst_n = 1'b0;
    #1;
    check("t5_rst_outs", {27'd0, busy, done, overrun, vram_rden, row_wren}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    saved = wr_cnt;
    run(20);
    check("t5_stays_idle", {31'd0, busy}, 32'h0);
    check("t5_no_writes", wr_cnt - saved, 0);

    // Color-0 handling.
    for (int i = 0; i < 8; i++) vram[16'h2008 + i] = 32'h0000_0010;
    clear_buf();
    start_row(8'd0, 32'h0);
    run(600);
    check("t6_done_at", done_at, 493);
    check("t6_px1", {24'd0, rowbuf[1]}, 32'h21);
`ifdef PPU_BG_TRANSPARENT_SKIP_EN
    check("t6_wr_cnt", wr_cnt, 40);
    check("t6_px0", {24'd0, rowbuf[0]}, 32'hFF);
`else
    check("t6_wr_cnt", wr_cnt, 320);
    check("t6_px0", {24'd0, rowbuf[0]}, 32'h20);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
